// File: rtl/cic_frame_buffer.sv
// Pairs channel A/B CIC samples into 48-bit frames and queues them in a show-ahead FIFO
// for the I2C slave; the asynchronous frame_pop acknowledge is synchronized and edge-detected here.
module cic_frame_buffer #(
  parameter int SAMPLE_W = 24,
  parameter int DEPTH    = 64,
  parameter int BATCH    = 36,
  parameter int LVL_W    = 7
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid,
  input  logic                  sample_ch,
  input  logic                  frame_pop,
  input  logic                  clr_err,
  output logic [2*SAMPLE_W-1:0] frame_out,
  output logic                  frame_full,
  output logic                  frame_avail,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  align_err
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int PTR_W   = LVL_W - 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] BATCH_LVL = LVL_W'(BATCH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] HAVE_A = 1'b1;

  logic [0:0]          state_reg, state_next;
  logic [SAMPLE_W-1:0] a_reg, a_next;
  logic                wr_req, align_evt;
  logic [FRAME_W-1:0]  wr_data;

  logic                pop_meta_reg, pop_sync_reg, pop_sync_d_reg;
  logic                pop_commit, pop_do, wr_ok;

  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg, level_next;
  logic [FRAME_W-1:0]  frame_reg, frame_next;
  logic                full_reg, avail_reg;
  logic                overflow_reg, underflow_reg, align_err_reg;

  logic [FRAME_W-1:0]  mem [DEPTH];

  // Pairing FSM: a frame is only formed from an A sample directly followed by a B sample.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    wr_req     = 1'b0;
    align_evt  = 1'b0;
    if (sample_valid) begin
      case (state_reg)
        IDLE: begin
          if (sample_ch) begin
            align_evt = 1'b1;
          end else begin
            a_next     = sample_in;
            state_next = HAVE_A;
          end
        end
        default: begin
          if (sample_ch) begin
            wr_req     = 1'b1;
            state_next = IDLE;
          end else begin
            a_next    = sample_in;
            align_evt = 1'b1;
          end
        end
      endcase
    end
  end

  assign wr_data    = {sample_in, a_reg};
  assign pop_commit = pop_sync_reg & ~pop_sync_d_reg;
  assign pop_do     = pop_commit && (level_reg != '0);
  assign wr_ok      = wr_req && ((level_reg < DEPTH_LVL) || pop_do);
  assign level_next = level_reg + LVL_W'(wr_ok) - LVL_W'(pop_do);

  // Head lookahead: after a pop the next entry is either already stored or is the frame arriving now.
  always_comb begin
    frame_next = frame_reg;
    if (pop_do) begin
      if (level_reg == LVL_W'(1)) begin
        if (wr_ok) frame_next = wr_data;
      end else begin
        frame_next = mem[rd_ptr_reg + PTR_W'(1)];
      end
    end else if (wr_ok && (level_reg == '0)) begin
      frame_next = wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      pop_meta_reg   <= 1'b0;
      pop_sync_reg   <= 1'b0;
      pop_sync_d_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      frame_reg      <= '0;
      full_reg       <= 1'b0;
      avail_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      align_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      pop_meta_reg   <= frame_pop;
      pop_sync_reg   <= pop_meta_reg;
      pop_sync_d_reg <= pop_sync_reg;
      if (wr_ok)  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_do) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg      <= level_next;
      frame_reg      <= frame_next;
      full_reg       <= (level_next >= BATCH_LVL);
      avail_reg      <= (level_next != '0);
      // An error event in the clearing cycle keeps its flag set.
      overflow_reg   <= (overflow_reg  & ~clr_err) | (wr_req && !wr_ok);
      underflow_reg  <= (underflow_reg & ~clr_err) | (pop_commit && (level_reg == '0));
      align_err_reg  <= (align_err_reg & ~clr_err) | align_evt;
    end
  end

  assign frame_out   = frame_reg;
  assign frame_full  = full_reg;
  assign frame_avail = avail_reg;
  assign level       = level_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;
  assign align_err   = align_err_reg;

endmodule

// File: doc/cic_frame_buffer.md
Name: cic_frame_buffer

Overview:
- Sits directly upstream of the I2C slave transmitter, between the CIC decimator output and the I2C slave's 48-bit data / full inputs.
- Pairs consecutive two-channel 24-bit CIC samples into 48-bit frames and buffers them in a show-ahead FIFO.
- Asserts frame_full once a complete batch is available, so the host MCU can drain a whole batch over I2C.
- The I2C side acknowledges each transmitted frame with a pop pulse; this block synchronizes that pulse.

Parameters:
SAMPLE_W, 24, width of one CIC sample; frame width is 2*SAMPLE_W.
DEPTH, 64, FIFO capacity in frames; must be a power of two.
BATCH, 36, frame count at which frame_full asserts; must satisfy 1 <= BATCH <= DEPTH.
LVL_W, 7, width of level; equals log2(DEPTH)+1.

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
reset_n  in  1  asynchronous active-low reset.
sample_in  in  SAMPLE_W  CIC sample.
sample_valid  in  1  one-cycle strobe qualifying sample_in and sample_ch.
sample_ch  in  1  channel tag: 0 = channel A, 1 = channel B.
frame_pop  in  1  consumer done-with-head indication; asynchronous to sys_clk, acted on at its rising edge.
clr_err  in  1  synchronous clear of sticky error flags.
frame_out  out  2*SAMPLE_W  FIFO head, packed {chB, chA}; chA occupies bits [23:0], which the I2C side sends as its first byte.
frame_full  out  1  high while level >= BATCH.
frame_avail  out  1  high while level > 0.
level  out  LVL_W  frames currently stored, 0..DEPTH.
overflow  out  1  sticky: a completed frame was dropped because the FIFO was full.
underflow  out  1  sticky: a pop arrived while the FIFO was empty.
align_err  out  1  sticky: the channel sequence broke A-then-B pairing.

Behaviour:
Reset (reset_n = 0, asynchronous):
- Pointers and level = 0; pending flag cleared.
- frame_out = 0; frame_full, frame_avail, overflow, underflow and align_err all = 0.
- Pop synchronizer flops = 0.
- Reset asserted mid-operation discards all stored and pending data, with no partial frame retained.

Pairing state machine (states IDLE, HAVE_A):
- IDLE, valid with ch = 0: latch sample into the A register, go to HAVE_A.
- IDLE, valid with ch = 1: drop the sample, set align_err, stay in IDLE.
- HAVE_A, valid with ch = 1: form {sample_in, A_reg}, issue a write request, go to IDLE.
- HAVE_A, valid with ch = 0: overwrite A_reg, set align_err, stay in HAVE_A.

Write:
- Accepted if level < DEPTH, or if a pop is committed in the same cycle.
- Otherwise the frame is dropped and overflow is set; level stays DEPTH.

Pop:
- frame_pop passes through a 2-FF synchronizer plus an edge register.
- A pop commits on the cycle the synchronized signal rises: 2-3 sys_clk after the asynchronous rising edge.
- Pop with level = 0 sets underflow and changes nothing else.
- A held-high frame_pop produces exactly one pop.

Simultaneous write and pop:
- Both occur; level is unchanged.
- This also applies at level = DEPTH, where the write is accepted.
- At level = 0, the write is accepted and the pop is an underflow.

Output timing:
- frame_out is registered and show-ahead; it updates the cycle after any write or pop that changes the head.
- Writing into an empty FIFO: frame_out and frame_avail are valid 1 cycle after the write cycle.
- When the FIFO empties, frame_out holds its last value.

Status and flags:
- level, frame_full and frame_avail are registered and reflect the post-update count in the same cycle frame_out updates.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- clr_err clears all sticky flags. An error event in the same cycle as clr_err wins, so the flag stays set.

Test Plan:
1. Reset, then A=0x000001 and B=0x000002 -> frame_out = 0x000002000001 and level = 1 one cycle after the B strobe; frame_full = 0.
2. Push 36 A/B pairs with values = index -> frame_full rises on the cycle level reaches 36. Pop 36 times with a frame_pop asynchronous to sys_clk -> frames emerge in order, level returns to 0, frame_full falls at level 35, underflow = 0.
3. Fill to 64, push one more pair -> overflow = 1, level = 64, head unchanged. Then pop and write in the same cycle -> level remains 64 and the new frame lands at the tail.
4. Sequence ch: 1, 0, 0, 1 with values 0x10, 0x20, 0x30, 0x40 -> align_err = 1, exactly one frame 0x000040000030 stored. clr_err -> align_err = 0.
5. Pop with the FIFO empty -> underflow = 1, level = 0, frame_out unchanged. Hold frame_pop high for 10 cycles with 2 frames stored -> exactly one frame removed.
6. Assert reset_n low asynchronously mid-fill at level 20 while in HAVE_A -> all outputs 0 immediately. After release, a lone ch = 1 sample sets align_err, and a subsequent A/B pair yields level = 1.
